da_accumulator: RTL

Shift-accumulate output stage of the distributed-arithmetic FIR filter. Sits directly downstream of the filter control unit and the coefficient LUT. Each enabled bit cycle it adds the LUT partial sum, weighted by the bit index, into a full-precision accumulator, with the sign-bit slice subtracted. At time slot end (`ts`) it scales the accumulator, narrows it to the output width and presents it on a valid/ready output port.

---
 rtl/da_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/da_accumulator.sv
// DA FIR shift-accumulate output stage: one result per frame, y/y_valid registered one cycle after ts&filter_en.
// Single-entry output register, no backpressure upstream (overwrites set overrun); DA_ACC_SAT_EN selects clamping over wrap.
module da_accumulator #(
  parameter int WORD_WIDTH = 16,
  parameter int LUT_WIDTH  = 20,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_SHIFT  = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        filter_en,
  input  logic                        ts,
  input  logic signed [LUT_WIDTH-1:0] lut_data,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        overrun,
  output logic                        drop,
  output logic                        sat,
  input  logic                        clr_flags
);

  localparam int ACC_WIDTH = LUT_WIDTH + WORD_WIDTH;
  localparam int KW        = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [KW-1:0] K_ONE = KW'(1);

  logic [KW-1:0]                r_k;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_active;
  logic signed [OUT_WIDTH-1:0]  r_y;
  logic                         r_y_valid;
  logic                         r_overrun;
  logic                         r_drop;

  logic signed [ACC_WIDTH-1:0]  w_l;
  logic signed [ACC_WIDTH-1:0]  w_l_shk;
  logic signed [ACC_WIDTH-1:0]  w_final;
  logic signed [ACC_WIDTH-1:0]  w_s;
  logic signed [OUT_WIDTH-1:0]  w_y_next;
  logic                         w_new;
  logic                         w_drop;

  assign w_l      = {{WORD_WIDTH{lut_data[LUT_WIDTH-1]}}, lut_data};
  assign w_l_shk  = w_l << r_k;
  // The ts slice carries the sample sign bit, so its weight is negative.
  assign w_final  = r_acc - (w_l << (WORD_WIDTH - 1));
  assign w_s      = w_final >>> OUT_SHIFT;
  assign w_new    = filter_en & ts;
  assign w_drop   = ts & ~filter_en & r_active;

`ifdef DA_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic w_clip;
  logic r_sat;

  always_comb begin
    w_clip   = 1'b0;
    w_y_next = w_s[OUT_WIDTH-1:0];
    if (w_s > SAT_MAX) begin
      w_clip   = 1'b1;
      w_y_next = SAT_MAX[OUT_WIDTH-1:0];
    end else if (w_s < SAT_MIN) begin
      w_clip   = 1'b1;
      w_y_next = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= (w_new & w_clip) | (r_sat & ~clr_flags);
    end
  end

  assign sat = r_sat;
`else
  logic w_unused_hi;

  assign w_y_next    = w_s[OUT_WIDTH-1:0];
  assign w_unused_hi = ^w_s[ACC_WIDTH-1:OUT_WIDTH];
  assign sat         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k      <= '0;
      r_acc    <= '0;
      r_active <= 1'b0;
    end else begin
      if (ts) begin
        r_k <= '0;
      end else if (filter_en) begin
        r_k <= r_k + K_ONE;
      end

      if (ts) begin
        r_active <= 1'b0;
      end else if (filter_en) begin
        r_active <= 1'b1;
      end

      // First slice loads so no explicit clear is needed between frames.
      if (filter_en && !ts) begin
        if (r_k == '0) begin
          r_acc <= w_l;
        end else begin
          r_acc <= r_acc + w_l_shk;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      if (w_new) begin
        r_y       <= w_y_next;
        r_y_valid <= 1'b1;
      end else if (r_y_valid && y_ready) begin
        r_y_valid <= 1'b0;
      end
      r_overrun <= (w_new & r_y_valid & ~y_ready) | (r_overrun & ~clr_flags);
      r_drop    <= w_drop | (r_drop & ~clr_flags);
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign overrun = r_overrun;
  assign drop    = r_drop;

endmodule
